// File: rtl/rv_core_fetch_if.sv
// AXI4 read-channel bundle between the fetch front end and the read interconnect.
// There is no arready: the interconnect takes the address in the cycle arvalid is high.
interface rv_core_fetch_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [3:0]  arcache;
    logic        rvalid;
    logic        rlast;
    logic [63:0] rdata;
    logic        rready;

    modport master (
        output araddr, arvalid, arburst, arsize, arlen, arcache, rready,
        input  rvalid, rlast, rdata
    );

    modport slave (
        input  araddr, arvalid, arburst, arsize, arlen, arcache, rready,
        output rvalid, rlast, rdata
    );
endinterface

// File: rtl/rv_core_fetch.sv
// Instruction-fetch front end: one AXI4 INCR read burst per host command, 64-bit beats
// folded into a beat count and a 32-bit XOR checksum reported through fetch_status.
module rv_core_fetch #(
    parameter logic [3:0] ARCACHE_VAL = 4'b0011
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  data_in,
    input  logic          write,
    rv_core_fetch_if.master axi,
    output logic [63:0]   fetch_status
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state, state_next;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [7:0]  beat_cnt;
    logic [8:0]  beats_total;
    logic [31:0] checksum;
    logic        busy, done, error;
    logic        cmd_accept, beat_accept;
    logic        reserved_unused;

    assign reserved_unused = ^data_in[127:40];

    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arburst = 2'b01;
    assign axi.arsize  = 3'b011;
    assign axi.arcache = ARCACHE_VAL;

    assign fetch_status = {checksum, 16'h0000, beat_cnt, 5'b00000, error, done, busy};

    always_comb begin
        state_next  = state;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        cmd_accept  = 1'b0;
        beat_accept = 1'b0;
        case (state)
            IDLE: begin
                if (write) begin
                    cmd_accept = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                axi.arvalid = 1'b1;
                state_next  = DATA;
            end
            DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    beat_accept = 1'b1;
                    if (axi.rlast) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // beats_total is 9 bits so a full 256-beat burst can be told apart from an empty one,
    // while the reported beat_cnt wraps at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            araddr_q    <= 32'h0;
            arlen_q     <= 8'h0;
            beat_cnt    <= 8'h0;
            beats_total <= 9'h0;
            checksum    <= 32'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state <= state_next;
            if (cmd_accept) begin
                araddr_q    <= {data_in[31:3], 3'b000};
                arlen_q     <= data_in[39:32];
                beat_cnt    <= 8'h0;
                beats_total <= 9'h0;
                checksum    <= 32'h0;
                busy        <= 1'b1;
                done        <= 1'b0;
                error       <= 1'b0;
            end
            if (beat_accept) begin
                beat_cnt    <= beat_cnt + 8'd1;
                beats_total <= beats_total + 9'd1;
                checksum    <= checksum ^ axi.rdata[63:32] ^ axi.rdata[31:0];
                if (axi.rlast) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (beats_total != {1'b0, arlen_q}) error <= 1'b1;
                end else if (beats_total == {1'b0, arlen_q}) begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_core_fetch.sv
// Scoreboard bench for rv_core_fetch: commands push expected AR requests and final status
// words; a negedge monitor pops and compares when arvalid or a done rising edge appears.
module tb_rv_core_fetch;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] data_in;
    logic         write;
    logic [63:0]  fetch_status;

    int check_count = 0;
    int fail_count  = 0;

    ar_exp_t     ar_q[$];
    logic [63:0] status_q[$];

    rv_core_fetch_if axi_bus ();

    rv_core_fetch #(.ARCACHE_VAL(4'b0011)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .write        (write),
        .axi          (axi_bus),
        .fetch_status (fetch_status)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [31:0] exp_addr, input bit expect_done,
                                  input logic [63:0] exp_status);
        ar_exp_t e;
        int n;
        e.addr = exp_addr;
        e.len  = len;
        ar_q.push_back(e);
        if (expect_done) status_q.push_back(exp_status);
        data_in = {{88{1'b1}}, len, addr};
        write   = 1'b1;
        @(posedge clk);
        #1;
        write   = 1'b0;
        data_in = '0;
        n = 0;
        while (axi_bus.rready !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("rready_latency", 64'(n), 64'd1);
    endtask

    task automatic send_beat(input logic [63:0] d, input bit last, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = d;
        axi_bus.rlast  = last;
        @(posedge clk);
        #1;
        axi_bus.rvalid = 1'b0;
        axi_bus.rlast  = 1'b0;
        axi_bus.rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    endtask

    // Monitor: one AR pop per arvalid pulse, one status pop per completion.
    logic prev_arvalid = 1'b0;
    logic prev_done    = 1'b0;
    always @(negedge clk) begin
        if (axi_bus.arvalid === 1'b1) begin
            check_output("arvalid_width", {63'h0, prev_arvalid}, 64'h0);
            if (ar_q.size() == 0) begin
                check_count++;
                fail_count++;
                $display("[TB] FAIL ar_unexpected: got araddr 0x%h, expected no request", axi_bus.araddr);
            end else begin
                ar_exp_t e;
                e = ar_q.pop_front();
                check_output("araddr", 64'(axi_bus.araddr), 64'(e.addr));
                check_output("arlen", 64'(axi_bus.arlen), 64'(e.len));
                check_output("arburst", 64'(axi_bus.arburst), 64'h1);
                check_output("arsize", 64'(axi_bus.arsize), 64'h3);
                check_output("arcache", 64'(axi_bus.arcache), 64'h3);
            end
        end
        if (fetch_status[1] === 1'b1 && prev_done !== 1'b1) begin
            check_output("rready_after_done", {63'h0, axi_bus.rready}, 64'h0);
            if (status_q.size() == 0) begin
                check_count++;
                fail_count++;
                $display("[TB] FAIL status_unexpected: got 0x%h, expected no completion", fetch_status);
            end else begin
                check_output("fetch_status", fetch_status, status_q.pop_front());
            end
        end
        prev_arvalid = axi_bus.arvalid;
        prev_done    = fetch_status[1];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        write          = 1'b1;
        data_in        = {88'h0, 8'h05, 32'h0000_ABCD};
        axi_bus.rvalid = 1'b0;
        axi_bus.rlast  = 1'b0;
        axi_bus.rdata  = '0;

        // Reset with write held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_arvalid", {63'h0, axi_bus.arvalid}, 64'h0);
        check_output("reset_rready", {63'h0, axi_bus.rready}, 64'h0);
        check_output("reset_status", fetch_status, 64'h0);
        check_output("reset_araddr", 64'(axi_bus.araddr), 64'h0);
        check_output("reset_arburst", 64'(axi_bus.arburst), 64'h1);
        check_output("reset_arsize", 64'(axi_bus.arsize), 64'h3);
        check_output("reset_arcache", 64'(axi_bus.arcache), 64'h3);
        write = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, unaligned address
        apply_stimulus(32'h0000_1004, 8'd0, 32'h0000_1000, 1'b1, 64'h0000_0080_0000_0102);
        send_beat(64'h0000_0013_0000_0093, 1'b1, 0);

        // Burst of 4 with rvalid gaps
        apply_stimulus(32'h0000_2010, 8'd3, 32'h0000_2010, 1'b1, 64'h0000_0000_0000_0402);
        send_beat(64'h0000_0001_0000_0001, 1'b0, 1);
        send_beat(64'h0000_0002_0000_0002, 1'b0, 0);
        send_beat(64'h0000_0003_0000_0003, 1'b0, 2);
        send_beat(64'h0000_0004_0000_0004, 1'b1, 1);

        // Early rlast
        apply_stimulus(32'h0000_4008, 8'd3, 32'h0000_4008, 1'b1, 64'h0000_0111_0000_0206);
        send_beat(64'h0000_0010_0000_0001, 1'b0, 0);
        send_beat(64'h0000_0100_0000_0000, 1'b1, 1);
        check_output("rready_drop", {63'h0, axi_bus.rready}, 64'h0);

        // Overrun past arlen+1
        apply_stimulus(32'h0000_6007, 8'd1, 32'h0000_6000, 1'b1, 64'h000C_0B0A_0000_0306);
        send_beat(64'h0000_0000_0000_000A, 1'b0, 0);
        send_beat(64'h0000_0000_0000_0B00, 1'b0, 0);
        send_beat(64'h0000_0000_000C_0000, 1'b1, 0);

        // Write while busy, then reset mid-burst
        apply_stimulus(32'h0000_2000, 8'd3, 32'h0000_2000, 1'b0, 64'h0);
        send_beat(64'h1111_1111_2222_2222, 1'b0, 0);
        data_in = {88'h0, 8'd7, 32'h0000_5000};
        write   = 1'b1;
        @(posedge clk);
        #1;
        write   = 1'b0;
        data_in = '0;
        check_output("busy_araddr", 64'(axi_bus.araddr), 64'h0000_2000);
        check_output("busy_arlen", 64'(axi_bus.arlen), 64'h3);
        check_output("busy_rready", {63'h0, axi_bus.rready}, 64'h1);
        send_beat(64'h3333_3333_4444_4444, 1'b0, 0);
        rst_n          = 1'b0;
        axi_bus.rvalid = 1'b1;
        axi_bus.rlast  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        axi_bus.rvalid = 1'b0;
        axi_bus.rlast  = 1'b0;
        check_output("midreset_rready", {63'h0, axi_bus.rready}, 64'h0);
        check_output("midreset_araddr", 64'(axi_bus.araddr), 64'h0);
        check_output("midreset_arlen", 64'(axi_bus.arlen), 64'h0);
        check_output("midreset_status", fetch_status, 64'h0);

        // Normal command after reset
        apply_stimulus(32'h0000_300C, 8'd0, 32'h0000_3008, 1'b1, 64'h0000_0003_0000_0102);
        send_beat(64'h0000_0001_0000_0002, 1'b1, 1);

        repeat (5) @(posedge clk);
        #1;
        check_output("ar_queue_empty", 64'(ar_q.size()), 64'h0);
        check_output("status_queue_empty", 64'(status_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/rv_core_fetch.md
Name: rv_core_fetch

Overview:
- Instruction-fetch front end of the superscalar RISC-V core. It issues one AXI4 read burst per host fetch command and accepts the 64-bit beats, each beat holding one instruction pair.
- It exposes a status word carrying busy/done/error flags, the beat count and a 32-bit XOR checksum of the fetched instructions.
- It sits between the core's command interface and the AXI read interconnect.

Parameters:
- ARCACHE_VAL, 4'b0011, constant value driven on arcache (normal, non-cacheable, bufferable).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  128  fetch command word:
  - [31:0] start address.
  - [39:32] burst length minus one.
  - [127:40] reserved, ignored.
- write  in  1  command strobe; sampled only in IDLE.
- rvalid  in  1  AXI read data valid.
- rlast  in  1  AXI last beat of burst.
- rdata  in  64  AXI read data; one instruction pair per beat.
- rready  out  1  AXI read data ready.
- araddr  out  32  AXI read address.
- arvalid  out  1  AXI read address valid.
- arburst  out  2  constant 2'b01 (INCR).
- arsize  out  3  constant 3'b011 (8 bytes/beat).
- arlen  out  8  beats minus one.
- arcache  out  4  constant ARCACHE_VAL.
- fetch_status  out  64  status word:
  - [0] busy.
  - [1] done.
  - [2] error.
  - [7:3] zero.
  - [15:8] beat count.
  - [31:16] zero.
  - [63:32] checksum.

Behaviour:
- All state updates on the rising clk edge. Reset is synchronous: rst_n low at an edge forces the reset state, regardless of state or an in-flight burst; the abandoned burst's remaining beats are ignored.
- Reset values:
  - arvalid=0, rready=0, araddr=0, arlen=0.
  - fetch_status=0.
  - arburst, arsize and arcache are constants at all times, including reset.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If write=1: latch araddr = {data_in[31:3], 3'b000} (forced 8-byte alignment) and arlen = data_in[39:32].
  - Clear beat count, checksum, done and error; set busy; go to ADDR.
  - write=0: stay in IDLE, outputs hold.
- ADDR:
  - arvalid=1 for exactly one cycle. There is no arready; the interconnect accepts the address in the cycle arvalid is high.
  - Next state DATA; arvalid returns to 0.
- DATA:
  - rready=1 throughout DATA.
  - A beat is accepted on any edge with rvalid=1 and rready=1. On acceptance:
    - beat count += 1 (8-bit, wraps, so a 256-beat burst reads 0).
    - checksum ^= rdata[63:32] ^ rdata[31:0].
  - Accepted beat with rlast=1:
    - error set if the number of accepted beats, including this one, != arlen+1.
    - busy cleared, done set; go to IDLE. rready=0 from the next cycle.
  - If beat arlen+1 is accepted without rlast: set error, keep accepting until rlast.
  - rvalid while not in DATA is ignored; rready is 0 there.
- write while busy (ADDR/DATA) is ignored; no queueing.
- done and error are sticky until the next accepted command or reset.
- araddr and arlen hold their latched values until the next command.
- Latency: write accepted at edge t; arvalid high during cycle t+1; rready high from cycle t+2; the first beat can be accepted at the edge ending cycle t+2.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with write=1 → arvalid=0, rready=0, fetch_status=0, arburst=01, arsize=011, arcache=0011.
2. Single beat:
   - Stimulus: write with data_in[31:0]=0x0000_1004, [39:32]=0; one beat rdata=0x0000_0013_0000_0093 with rlast.
   - Response: araddr=0x0000_1000, arlen=0, one-cycle arvalid; status busy=0, done=1, error=0, count=1, checksum=0x0000_0080.
3. Burst of 4:
   - Stimulus: arlen=3; beats 0x1_00000001, 0x2_00000002, 0x3_00000003, 0x4_00000004 with rlast on the 4th; insert rvalid gaps.
   - Response: count=4, checksum=0x0000_0000, error=0.
4. Length mismatch: arlen=3, rlast on 2nd beat → done=1, error=1, count=2, rready drops the cycle after.
5. Overrun: arlen=1, 3 beats with rlast on the 3rd → error=1, count=3.
6. Busy and reset:
   - Stimulus: second write during DATA; then rst_n=0 mid-burst.
   - Response: second write ignored (araddr unchanged); after reset all outputs return to reset values and the next command works normally.
